uart_frame_sequencer: RTL and testbench
=======================================

// Module: uart_frame_sequencer
// PURPOSE
//  Shares the single uart_tx byte transmitter between NUM_REQ record producers (LPC trace, status).
//  Round-robin grants one record per requester, captures it, then emits a header byte + REC_BYTES
//  payload bytes, MSB first, through the uart_tx ready/read_latch handshake. Sits between the LPC decode
//  logic and uart_tx, in the system clock domain.
// PARAMETERS
//  NUM_REQ      2    number of requesters (1..15)
//  REC_BYTES    6    payload bytes per record (1..16)
//  ACK_TIMEOUT  255  clocks to wait for uart_ready to fall after a latch before flagging an error
//  HDR_PREFIX   4'hF upper nibble of header byte; lower nibble = granted requester index
// PORTS
//  clock        in   1                    system clock, all logic on posedge
//  reset        in   1                    synchronous, active-high
//  req_valid    in   NUM_REQ              requester i has a record; held until req_ack[i]
//  req_data     in   NUM_REQ*REC_BYTES*8  record i at [i*REC_BYTES*8 +: REC_BYTES*8], byte 0 = MSB
//  req_ack      out  NUM_REQ              one-cycle pulse: record i captured, may change next cycle
//  uart_data    out  8                    byte to uart_tx read_data, stable from LATCH until WAIT_HIGH exit
//  uart_latch   out  1                    one-cycle high pulse to uart_tx read_latch
//  uart_ready   in   1                    uart_tx ready (slow domain; treated as level, 2-flop synced)
//  busy         out  1                    high in any state other than IDLE
//  timeout_err  out  1                    sticky; set on ACK_TIMEOUT expiry, cleared only by reset
// BEHAVIOUR
//  Reset (synchronous, active-high): state=IDLE, req_ack=0, uart_latch=0, uart_data=0, busy=0,
//   timeout_err=0, rr pointer=NUM_REQ-1 (so requester 0 wins first). Reset mid-frame abandons
//   the frame; no further bytes; uart_latch is low from the cycle after reset is sampled.
//  FSM:
//   IDLE     : if any req_valid -> GRANT (same cycle: pick winner, pulse req_ack[w], capture
//              req_data[w] into shift reg, hdr={HDR_PREFIX,w}, byte_cnt=0, ptr=w).
//   LATCH    : entered from GRANT/NEXT only when synced ready=1; drive uart_data, uart_latch=1 for
//              exactly one cycle; clear timeout counter -> WAIT_LOW.
//   WAIT_LOW : synced ready=0 -> WAIT_HIGH; counter==ACK_TIMEOUT -> set timeout_err, -> NEXT
//              (byte counted as sent; no retry).
//   WAIT_HIGH: synced ready=1 -> NEXT. No timeout (uart_tx always finishes).
//   NEXT     : byte_cnt==REC_BYTES -> IDLE, else shift reg left 8, byte_cnt+1 -> LATCH.
//   GRANT    : -> LATCH (header byte) when synced ready=1, else waits.
//  Byte order: header, then req_data byte 0 (bits [REC_BYTES*8-1 -: 8]) ... byte REC_BYTES-1.
//  Arbitration: search starts at (ptr+1) mod NUM_REQ, wraps; first valid wins. Only evaluated in
//   IDLE; requests arriving mid-frame wait. Simultaneous requests -> rr order strictly alternates.
//  req_valid dropped before ack: simply not granted; no state effect. At most one req_ack bit set.
//  Latency: req_valid in IDLE at cycle t -> req_ack at t; first uart_latch >= t+2 (ready already high).
//  Widths: byte_cnt clog2(REC_BYTES+1); timeout counter clog2(ACK_TIMEOUT+1), saturating.
//  busy=0 only in IDLE; back-to-back frames return to IDLE for one cycle between records.
// STRUCTURE
//  Package uart_seq_pkg: state enum (IDLE,GRANT,LATCH,WAIT_LOW,WAIT_HIGH,NEXT), HDR_PREFIX default,
//   clog2 helper.
//  One sub-module: rr_arbiter (NUM_REQ req vector + ptr -> one-hot grant + index, combinational).
//  Top holds FSM, capture/shift register, counters, ready synchronizer.
// TESTING
//  Bench uses a uart_tx behavioural model: ready falls 3 clk after latch, rises 40 clk later.
//  1 single req0, data 48'h0102_0304_0506 -> ack[0] one pulse; bytes F0,01,02,03,04,05,06; busy->0.
//  2 req0 & req1 held continuously -> frames alternate F0,F1,F0,F1; never two acks same cycle.
//  3 req1 asserts mid-frame of req0 -> req1 frame starts only after req0's 7th byte completes.
//  4 model never drops ready -> after ACK_TIMEOUT+1 clk timeout_err=1, next byte latched; stays set.
//  5 reset asserted after 3rd byte latched -> next cycle uart_latch=0, busy=0, no further latches;
//    post-reset req1 alone -> header F1 (ptr reset).
//  6 req_data changed the cycle after ack -> transmitted payload equals the captured value.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// ---------------------------------------------------------------------------
// uart_seq_pkg : shared types and helpers for the UART frame sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    LATCH     = 3'd2,
    WAIT_LOW  = 3'd3,
    WAIT_HIGH = 3'd4,
    NEXT      = 3'd5
  } state_t;

  localparam logic [3:0] HDR_PREFIX_DEF = 4'hF;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_frame_sequencer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, search starts after i_ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [3:0]         i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [3:0]         o_idx,
  output logic               o_any
);

  logic w_found;

  // Two passes: indices above the pointer first, then wrap to 0..ptr.
  always_comb begin
    w_found = 1'b0;
    o_grant = '0;
    o_idx   = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && (4'(i) > i_ptr) && i_req[i]) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = 4'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && (4'(i) <= i_ptr) && i_req[i]) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = 4'(i);
      end
    end
    o_any = w_found;
  end

endmodule

`default_nettype wire

// File: rtl/uart_frame_sequencer.sv
// ---------------------------------------------------------------------------
// uart_frame_sequencer : round-robin record capture, header + payload to uart_tx
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_frame_sequencer
  import uart_seq_pkg::*;
#(
  parameter int         NUM_REQ     = 2,
  parameter int         REC_BYTES   = 6,
  parameter int         ACK_TIMEOUT = 255,
  parameter logic [3:0] HDR_PREFIX  = HDR_PREFIX_DEF
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*REC_BYTES*8-1:0] i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ack,
  output logic [7:0]                     o_uart_data,
  output logic                           o_uart_latch,
  input  logic                           i_uart_ready,
  output logic                           o_busy,
  output logic                           o_timeout_err
);

  localparam int REC_W = REC_BYTES * 8;
  localparam int SH_W  = REC_W + 8;
  localparam int CNT_W = clog2(REC_BYTES + 1);
  localparam int TMO_W = clog2(ACK_TIMEOUT + 1);

  state_t             r_state, w_next;
  logic               r_rdy_s1, r_rdy_s2;
  logic [3:0]         r_ptr;
  logic [SH_W-1:0]    r_shreg;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_timeout_err;
  logic [NUM_REQ-1:0] w_grant;
  logic [3:0]         w_idx;
  logic               w_any;
  logic [REC_W-1:0]   w_rec;
  logic               w_capture, w_shift, w_set_err;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_rec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_rec = i_req_data[i*REC_W +: REC_W];
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_shift   = 1'b0;
    w_set_err = 1'b0;
    case (r_state)
      IDLE:      if (w_any) begin
                   w_next    = GRANT;
                   w_capture = 1'b1;
                 end
      GRANT:     if (r_rdy_s2) w_next = LATCH;
      LATCH:     w_next = WAIT_LOW;
      WAIT_LOW:  if (!r_rdy_s2) begin
                   w_next = WAIT_HIGH;
                 end else if (r_tmo == TMO_W'(ACK_TIMEOUT)) begin
                   w_set_err = 1'b1;
                   w_next    = NEXT;
                 end
      WAIT_HIGH: if (r_rdy_s2) w_next = NEXT;
      NEXT:      if (r_byte_cnt == CNT_W'(REC_BYTES)) begin
                   w_next = IDLE;
                 end else if (r_rdy_s2) begin
                   w_shift = 1'b1;
                   w_next  = LATCH;
                 end
      default:   w_next = IDLE;
    endcase
  end

  // Header sits above the payload so every byte leaves from the top of r_shreg.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_rdy_s1      <= 1'b0;
      r_rdy_s2      <= 1'b0;
      r_ptr         <= 4'(NUM_REQ - 1);
      r_shreg       <= '0;
      r_byte_cnt    <= '0;
      r_tmo         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rdy_s1 <= i_uart_ready;
      r_rdy_s2 <= r_rdy_s1;
      r_state  <= w_next;
      if (w_capture) begin
        r_shreg    <= {HDR_PREFIX, w_idx, w_rec};
        r_byte_cnt <= '0;
        r_ptr      <= w_idx;
      end else if (w_shift) begin
        r_shreg    <= {r_shreg[SH_W-9:0], 8'h00};
        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      end
      if (r_state == LATCH) begin
        r_tmo <= '0;
      end else if ((r_state == WAIT_LOW) && (r_tmo != TMO_W'(ACK_TIMEOUT))) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
      if (w_set_err) r_timeout_err <= 1'b1;
    end
  end

  assign o_req_ack     = ((r_state == IDLE) && !i_reset) ? w_grant : '0;
  assign o_uart_latch  = (r_state == LATCH);
  assign o_uart_data   = r_shreg[SH_W-1 -: 8];
  assign o_busy        = (r_state != IDLE);
  assign o_timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_sequencer : randomized bench with uart_tx model and frame scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_frame_sequencer;

  localparam int NUM_REQ     = 2;
  localparam int REC_BYTES   = 6;
  localparam int ACK_TIMEOUT = 255;
  localparam int REC_W       = REC_BYTES * 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*REC_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ack;
  logic [7:0]               uart_data;
  logic                     uart_latch;
  logic                     uart_ready;
  logic                     busy;
  logic                     timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int multi_ack = 0;

  int want  [NUM_REQ];
  int acked [NUM_REQ];
  logic             no_drop = 1'b0;
  logic             model_busy;
  logic             fixed_en = 1'b0;
  logic [REC_W-1:0] fixed_val = '0;
  int               fixed_gen = 0;

  logic [7:0] got_q [$];
  int         got_cyc_q [$];
  logic [7:0] exp_q [$];
  int         ack_q [$];
  int         ack_cyc_q [$];

  uart_frame_sequencer #(
    .NUM_REQ(NUM_REQ), .REC_BYTES(REC_BYTES), .ACK_TIMEOUT(ACK_TIMEOUT), .HDR_PREFIX(4'hF)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ack(req_ack), .o_uart_data(uart_data), .o_uart_latch(uart_latch),
    .i_uart_ready(uart_ready), .o_busy(busy), .o_timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [REC_W-1:0] rand_rec();
    return REC_W'({$urandom(), $urandom()});
  endfunction

  // uart_tx model: ready falls 3 clocks after a latch and rises 40 clocks later.
  initial begin
    uart_ready = 1'b1;
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_latch) begin
        got_q.push_back(uart_data);
        got_cyc_q.push_back(cyc);
        if (!no_drop) begin
          model_busy = 1'b1;
          repeat (3) @(negedge clk);
          uart_ready = 1'b0;
          repeat (40) @(negedge clk);
          uart_ready = 1'b1;
          model_busy = 1'b0;
        end
      end
    end
  end

  // Requester model: raises valid while records are owed, records the expected frame at ack,
  // then replaces the record the cycle after the ack.
  initial begin
    logic [NUM_REQ-1:0] a;
    int seen_gen;
    seen_gen = 0;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      want[i] = 0;
      acked[i] = 0;
      req_data[i*REC_W +: REC_W] = rand_rec();
    end
    forever begin
      @(negedge clk);
      a = rst ? '0 : req_ack;
      if (a != '0) begin
        if ($countones(a) != 1) multi_ack++;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (a[i]) begin
            ack_q.push_back(i);
            ack_cyc_q.push_back(cyc);
            exp_q.push_back({4'hF, 4'(i)});
            for (int b = 0; b < REC_BYTES; b++)
              exp_q.push_back(req_data[i*REC_W + REC_W - 8 - 8*b +: 8]);
            acked[i]++;
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (a[i]) req_data[i*REC_W +: REC_W] =
            (i == 0 && fixed_en) ? ~req_data[REC_W-1:0] : rand_rec();
      end
      if (fixed_gen != seen_gen) begin
        req_data[REC_W-1:0] = fixed_val;
        seen_gen = fixed_gen;
      end
      for (int i = 0; i < NUM_REQ; i++) req_valid[i] = (acked[i] < want[i]);
    end
  end

  function automatic logic all_done();
    for (int i = 0; i < NUM_REQ; i++) if (acked[i] < want[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget, input string tag);
    int quiet, n;
    quiet = 0;
    n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy && !model_busy && uart_ready && all_done()) quiet++; else quiet = 0;
    end
    vectors++;
    if (quiet < 4) begin
      miscompares++;
      $display("FAIL %s_idle: still busy after %0d cycles, required idle", tag, n);
    end
  endtask

  task automatic wait_latches(input int count, input int budget, input string tag);
    int n;
    n = 0;
    while (got_q.size() < count && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (got_q.size() < count) begin
      miscompares++;
      $display("FAIL %s_latch: %0d bytes seen, required %0d", tag, got_q.size(), count);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors += 5;
    if (req_ack !== '0)     begin miscompares++; $display("FAIL reset_ack: got %b required 0", req_ack); end
    if (uart_latch !== 1'b0) begin miscompares++; $display("FAIL reset_latch: got %b required 0", uart_latch); end
    if (uart_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h required 00", uart_data); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b required 0", timeout_err); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] exp_b [7];
    int gb, ab, a0;
    exp_b = '{8'hF0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    apply_reset();
    gb = got_q.size(); ab = ack_q.size(); a0 = acked[0];
    fixed_en = 1'b1; fixed_val = 48'h0102_0304_0506; fixed_gen++;
    @(negedge clk);
    want[0]++;
    wait_idle(2000, "single");
    fixed_en = 1'b0;
    vectors++;
    if (acked[0] - a0 != 1) begin miscompares++; $display("FAIL single_acks: got %0d required 1", acked[0] - a0); end
    vectors++;
    if (got_q.size() != gb + 7) begin miscompares++; $display("FAIL single_count: got %0d required 7", got_q.size() - gb); end
    for (int k = 0; k < 7; k++) begin
      vectors++;
      if (gb + k >= got_q.size() || got_q[gb+k] !== exp_b[k]) begin
        miscompares++;
        $display("FAIL single_byte%0d: got %h required %h", k, (gb + k < got_q.size()) ? got_q[gb+k] : 8'hxx, exp_b[k]);
      end
    end
    vectors++;
    if (ack_q.size() <= ab || got_q.size() <= gb || got_cyc_q[gb] - ack_cyc_q[ab] < 2) begin
      miscompares++;
      $display("FAIL single_latency: first latch not at least 2 cycles after ack");
    end
  endtask

  task automatic test_alternate();
    int gb, eb, ab, m0;
    apply_reset();
    gb = got_q.size(); eb = exp_q.size(); ab = ack_q.size(); m0 = multi_ack;
    want[0] += 2;
    want[1] += 2;
    wait_idle(6000, "alt");
    vectors++;
    if (ack_q.size() != ab + 4) begin miscompares++; $display("FAIL alt_acks: got %0d required 4", ack_q.size() - ab); end
    for (int k = 0; k < 4 && ab + k < ack_q.size(); k++) begin
      vectors++;
      if (ack_q[ab+k] != k % 2) begin miscompares++; $display("FAIL alt_order%0d: got %0d required %0d", k, ack_q[ab+k], k % 2); end
    end
    vectors++;
    if (multi_ack != m0) begin miscompares++; $display("FAIL alt_multi_ack: got %0d required 0", multi_ack - m0); end
    vectors++;
    if (got_q.size() - gb != 28) begin miscompares++; $display("FAIL alt_count: got %0d required 28", got_q.size() - gb); end
    for (int k = 0; k < 28 && gb + k < got_q.size() && eb + k < exp_q.size(); k++) begin
      vectors++;
      if (got_q[gb+k] !== exp_q[eb+k]) begin miscompares++; $display("FAIL alt_byte%0d: got %h required %h", k, got_q[gb+k], exp_q[eb+k]); end
    end
  endtask

  task automatic test_midframe();
    int gb, eb, ab;
    apply_reset();
    gb = got_q.size(); eb = exp_q.size(); ab = ack_q.size();
    want[0]++;
    wait_latches(gb + 2, 500, "mid");
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b required 1", busy); end
    want[1]++;
    wait_idle(3000, "mid");
    vectors++;
    if (ack_q.size() != ab + 2 || ack_q[ab] != 0 || ack_q[ab+1] != 1) begin
      miscompares++;
      $display("FAIL mid_order: %0d acks, order not req0 then req1", ack_q.size() - ab);
    end
    vectors++;
    if (ack_q.size() < ab + 2 || got_q.size() < gb + 7 || ack_cyc_q[ab+1] <= got_cyc_q[gb+6] + 43) begin
      miscompares++;
      $display("FAIL mid_wait: req1 granted before req0 frame completed");
    end
    for (int k = 0; k < 14; k++) begin
      vectors++;
      if (gb + k >= got_q.size() || eb + k >= exp_q.size() || got_q[gb+k] !== exp_q[eb+k]) begin
        miscompares++;
        $display("FAIL mid_byte%0d: byte missing or differs from captured record", k);
      end
    end
  endtask

  task automatic test_timeout();
    int gb, eb, gap;
    apply_reset();
    gb = got_q.size(); eb = exp_q.size();
    no_drop = 1'b1;
    want[0]++;
    wait_latches(gb + 1, 200, "tmo");
    repeat (ACK_TIMEOUT - 1) @(negedge clk);
    vectors++;
    if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_early: got %b required 0", timeout_err); end
    wait_latches(gb + 2, 400, "tmo");
    vectors++;
    if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_set: got %b required 1", timeout_err); end
    gap = (got_cyc_q.size() >= gb + 2) ? got_cyc_q[gb+1] - got_cyc_q[gb] : 0;
    vectors++;
    if (gap < ACK_TIMEOUT + 1 || gap > ACK_TIMEOUT + 4) begin
      miscompares++;
      $display("FAIL tmo_gap: got %0d cycles required %0d..%0d", gap, ACK_TIMEOUT + 1, ACK_TIMEOUT + 4);
    end
    wait_idle(3000, "tmo");
    for (int k = 0; k < 7; k++) begin
      vectors++;
      if (gb + k >= got_q.size() || eb + k >= exp_q.size() || got_q[gb+k] !== exp_q[eb+k]) begin
        miscompares++;
        $display("FAIL tmo_byte%0d: byte missing or differs from captured record", k);
      end
    end
    no_drop = 1'b0;
    want[1]++;
    wait_idle(2000, "tmo2");
    vectors++;
    if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky: got %b required 1", timeout_err); end
  endtask

  task automatic test_reset_midframe();
    int gb, eb;
    apply_reset();
    gb = got_q.size(); eb = exp_q.size();
    want[0]++;
    wait_latches(gb + 3, 500, "rstmid");
    rst = 1'b1;
    @(negedge clk);
    vectors += 2;
    if (uart_latch !== 1'b0) begin miscompares++; $display("FAIL rstmid_latch: got %b required 0", uart_latch); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    rst = 1'b0;
    repeat (100) @(negedge clk);
    vectors++;
    if (got_q.size() != gb + 3) begin miscompares++; $display("FAIL rstmid_extra: got %0d bytes required 3", got_q.size() - gb); end
    vectors++;
    if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_err: got %b required 0", timeout_err); end
    wait_idle(500, "rstmid");
    want[1]++;
    wait_idle(2000, "rstmid2");
    vectors++;
    if (got_q.size() < gb + 4 || got_q[gb+3] !== 8'hF1) begin miscompares++; $display("FAIL rstmid_hdr: header after reset not F1"); end
    for (int k = 1; k < 7; k++) begin
      vectors++;
      if (gb + 3 + k >= got_q.size() || eb + 7 + k >= exp_q.size() || got_q[gb+3+k] !== exp_q[eb+7+k]) begin
        miscompares++;
        $display("FAIL rstmid_byte%0d: byte missing or differs from captured record", k);
      end
    end
  endtask

  task automatic test_capture();
    logic [REC_W-1:0] v;
    int gb;
    apply_reset();
    gb = got_q.size();
    v = rand_rec();
    fixed_en = 1'b1; fixed_val = v; fixed_gen++;
    @(negedge clk);
    want[0]++;
    wait_idle(2000, "cap");
    fixed_en = 1'b0;
    for (int k = 0; k < REC_BYTES; k++) begin
      vectors++;
      if (gb + 1 + k >= got_q.size() || got_q[gb+1+k] !== v[REC_W-1-8*k -: 8]) begin
        miscompares++;
        $display("FAIL cap_byte%0d: got %h required %h", k, (gb + 1 + k < got_q.size()) ? got_q[gb+1+k] : 8'hxx, v[REC_W-1-8*k -: 8]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_midframe();
    test_timeout();
    test_reset_midframe();
    test_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
